// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data Avalon memory arbiter.
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERROR
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } arb_port_t;

  localparam logic [3:0] BE_FULL_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// bus_watchdog: counts waitrequest-stalled bus cycles and flags expiry on the
// cycle the count reaches TIMEOUT_CYCLES (used only with AVALON_TIMEOUT_EN).
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th stalled cycle so the owner leaves on that edge.
  assign expired = enable && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single Avalon-MM master, data priority.
// Optional bus timeout watchdog enabled by defining AVALON_TIMEOUT_EN.
module mem_arbiter
  import codes::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_byteen_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        stall_o,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        timeout_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_t state, state_next;
  arb_port_t  port_q;
  size_t      addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic [3:0] be_q;
  logic       we_q;
  logic       grant_d, grant_if;
  logic       wd_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_i) begin
          grant_d    = 1'b1;
          state_next = ACCESS;
        end else if (if_req_i) begin
          grant_if   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!waitrequest) begin
          state_next = RESP;
        end else if (wd_expired) begin
          state_next = ERROR;
        end
      end
      RESP:    state_next = IDLE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_q     <= PORT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_d) begin
        port_q  <= PORT_D;
        addr_q  <= d_addr_i;
        wdata_q <= d_wdata_i;
        be_q    <= d_byteen_i;
        we_q    <= d_we_i;
      end else if (grant_if) begin
        port_q  <= PORT_IF;
        addr_q  <= if_addr_i;
        wdata_q <= '0;
        be_q    <= BE_FULL_WORD;
        we_q    <= 1'b0;
      end
      if (state == ACCESS && !waitrequest) begin
        if (port_q == PORT_D) begin
          d_rdata_q <= readdata;
        end else begin
          if_rdata_q <= readdata;
        end
      end
    end
  end

`ifdef AVALON_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ACCESS && waitrequest),
    .clear  (grant_d || grant_if),
    .expired(wd_expired)
  );

  assign timeout_o = (state == ERROR);
`else
  assign wd_expired = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  assign read       = (state == ACCESS) && !we_q;
  assign write      = (state == ACCESS) && we_q;
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;

  assign if_valid_o = (state == RESP) && (port_q == PORT_IF);
  assign d_valid_o  = (state == RESP) && (port_q == PORT_D);
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;

  assign stall_o = (if_req_i | d_req_i) & ~(if_valid_o | d_valid_o);

endmodule
